genome_loader: RTL and testbench

Configuration writer for the evolvable logic array. Accepts a stream of 11-bit genome words, one per logic element, and writes them into a staging bank. After the last word it commits the whole bank atomically to the active configuration that drives every logic element's function-select and input-select fields. The array therefore never evaluates a half-loaded genome.

---
 rtl/genome_pkg.sv | 37 +++
 rtl/genome_bank.sv | 55 +++++
 rtl/genome_loader.sv | 148 ++++++++++++++
 tb/tb_genome_loader.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/genome_pkg.sv
`default_nettype none
// ============================================================================
// Module      : genome_pkg
// Description : Shared widths, function-code and FSM enums for the genome
//               loader and its configuration bank.
// Revision    : 1.0
// ============================================================================
package genome_pkg;

    localparam int CONF_W = 11;
    localparam int FUNC_W = 3;
    localparam int INS_W  = 8;
    localparam int SEL_W  = 4;

    typedef enum logic [FUNC_W-1:0] {
        FN_AND   = 3'd0,
        FN_OR    = 3'd1,
        FN_NOT_A = 3'd2,
        FN_XOR   = 3'd3,
        FN_XNOR  = 3'd4,
        FN_NAND  = 3'd5,
        FN_NOR   = 3'd6,
        FN_BUF_A = 3'd7
    } func_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_COMMIT = 2'd2
    } state_e;

    function automatic logic sel_out_of_range(input logic [SEL_W-1:0] sel, input int limit);
        return int'({28'd0, sel}) >= limit;
    endfunction

endpackage
`default_nettype wire

// File: rtl/genome_bank.sv
`default_nettype none
// ============================================================================
// Module      : genome_bank
// Description : Staging and active genome register files; a commit strobe
//               copies every staging slot into the active bank in one edge.
// Revision    : 1.0
// ============================================================================
module genome_bank
    import genome_pkg::*;
#(
    parameter int NUM_LE = 8,
    parameter int IDX_W  = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      i_wr_en,
    input  logic [IDX_W-1:0]          i_wr_idx,
    input  logic [CONF_W-1:0]         i_wr_word,
    input  logic                      i_commit,
    output logic [FUNC_W*NUM_LE-1:0]  o_func_all,
    output logic [INS_W*NUM_LE-1:0]   o_ins_all
);

    logic [CONF_W-1:0] r_stage  [NUM_LE];
    logic [CONF_W-1:0] r_active [NUM_LE];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_LE; i++) begin
                r_stage[i]  <= '0;
                r_active[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_LE; i++) begin
                if (i_wr_en && (i_wr_idx == IDX_W'(i))) begin
                    r_stage[i] <= i_wr_word;
                end
                if (i_commit) begin
                    r_active[i] <= r_stage[i];
                end
            end
        end
    end

    // Word layout is {func, ins_b, ins_a}; ins_b:ins_a form the 8-bit select field.
    genvar g;
    generate
        for (g = 0; g < NUM_LE; g++) begin : g_out
            assign o_func_all[FUNC_W*g +: FUNC_W] = r_active[g][CONF_W-1 -: FUNC_W];
            assign o_ins_all[INS_W*g +: INS_W]    = r_active[g][INS_W-1:0];
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/genome_loader.sv
`default_nettype none
// ============================================================================
// Module      : genome_loader
// Description : Streams NUM_LE genome words into a staging bank and commits
//               them atomically. Optional select range check enabled by the
//               macro GENOME_LOADER_RANGE_CHECK_EN.
// Revision    : 1.0
// ============================================================================
module genome_loader
    import genome_pkg::*;
#(
    parameter int NUM_LE     = 8,
    parameter int NUM_INPUTS = 11
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic                          abort,
    input  logic                          in_valid,
    input  logic [CONF_W-1:0]             in_data,
    output logic                          in_ready,
    output logic                          busy,
    output logic                          done,
    output logic                          err,
    output logic [$clog2(NUM_LE+1)-1:0]   load_count,
    output logic [FUNC_W*NUM_LE-1:0]      conf_func_all,
    output logic [INS_W*NUM_LE-1:0]       conf_ins_all
);

    localparam int CNT_W = $clog2(NUM_LE + 1);

    generate
        if (NUM_LE < 1 || NUM_INPUTS < 1 || NUM_INPUTS > (1 << SEL_W)) begin : g_bad_params
            $error("genome_loader: unsupported NUM_LE / NUM_INPUTS");
        end
    endgenerate

    state_e           r_state;
    state_e           w_state_nxt;
    logic [CNT_W-1:0] r_count;
    logic             r_done;
    logic             w_accept;
    logic             w_last;
    logic             w_commit;
    logic             w_load_ok;

    // abort has priority over a transfer presented in the same cycle.
    assign w_accept = (r_state == ST_LOAD) && in_valid && !abort;
    assign w_last   = (r_count == CNT_W'(NUM_LE - 1));
    assign w_commit = (r_state == ST_COMMIT);

`ifdef GENOME_LOADER_RANGE_CHECK_EN
    logic r_err;
    logic w_word_bad;

    assign w_word_bad = sel_out_of_range(in_data[SEL_W-1:0], NUM_INPUTS)
                     || sel_out_of_range(in_data[2*SEL_W-1:SEL_W], NUM_INPUTS);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_err <= 1'b0;
        end else if ((r_state == ST_IDLE) && start) begin
            r_err <= 1'b0;
        end else if (w_accept && w_word_bad) begin
            r_err <= 1'b1;
        end
    end

    // The final word is checked combinationally so a bad last word also vetoes the commit.
    assign w_load_ok = !(r_err || w_word_bad);
    assign err       = r_err;
`else
    assign w_load_ok = 1'b1;
    assign err       = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_nxt = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (abort) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_accept && w_last) begin
                    w_state_nxt = w_load_ok ? ST_COMMIT : ST_IDLE;
                end
            end
            ST_COMMIT: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // After an abort the count is left as-is so software can see how far the load got.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if ((r_state == ST_IDLE) && start) begin
            r_count <= '0;
        end else if (w_accept) begin
            r_count <= r_count + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_done <= 1'b0;
        end else begin
            r_done <= w_commit;
        end
    end

    genome_bank #(
        .NUM_LE (NUM_LE),
        .IDX_W  (CNT_W)
    ) u_bank (
        .clk        (clk),
        .rst        (rst),
        .i_wr_en    (w_accept),
        .i_wr_idx   (r_count),
        .i_wr_word  (in_data),
        .i_commit   (w_commit),
        .o_func_all (conf_func_all),
        .o_ins_all  (conf_ins_all)
    );

    assign in_ready   = (r_state == ST_LOAD);
    assign busy       = (r_state != ST_IDLE);
    assign done       = r_done;
    assign load_count = r_count;

endmodule
`default_nettype wire

// File: tb/tb_genome_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_genome_loader
// Description : Self-checking bench for genome_loader against a transaction
//               level model of the staging/active genome banks.
// Revision    : 1.0
// ============================================================================
module tb_genome_loader;
    import genome_pkg::*;

    localparam int NUM_LE     = 8;
    localparam int NUM_INPUTS = 11;
`ifdef GENOME_LOADER_RANGE_CHECK_EN
    localparam bit RC = 1'b1;
`else
    localparam bit RC = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        abort;
    logic        in_valid;
    logic [10:0] in_data;
    logic        in_ready;
    logic        busy;
    logic        done;
    logic        err;
    logic [3:0]  load_count;
    logic [23:0] conf_func_all;
    logic [63:0] conf_ins_all;

    genome_loader #(
        .NUM_LE     (NUM_LE),
        .NUM_INPUTS (NUM_INPUTS)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .abort         (abort),
        .in_valid      (in_valid),
        .in_data       (in_data),
        .in_ready      (in_ready),
        .busy          (busy),
        .done          (done),
        .err           (err),
        .load_count    (load_count),
        .conf_func_all (conf_func_all),
        .conf_ins_all  (conf_ins_all)
    );

    always #5 clk = ~clk;

    int          checks   = 0;
    int          failures = 0;
    int          ticks    = 0;
    bit          exp_err  = 1'b0;
    logic [10:0] exp_act  [NUM_LE];
    logic [10:0] ld_words [NUM_LE];

    typedef struct {
        int gap_mode;
        int abort_at;
        bit noise;
        bit exp_done;
    } vec_t;

    vec_t vecs [6];

    task automatic tick();
        @(posedge clk);
        #1;
        ticks++;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] model_func();
        logic [63:0] r = '0;
        for (int i = 0; i < NUM_LE; i++) r[3*i +: 3] = exp_act[i][10:8];
        return r;
    endfunction

    function automatic logic [63:0] model_ins();
        logic [63:0] r = '0;
        for (int i = 0; i < NUM_LE; i++) r[8*i +: 8] = exp_act[i][7:0];
        return r;
    endfunction

    function automatic bit word_bad(input logic [10:0] w);
        return (int'(w[3:0]) >= NUM_INPUTS) || (int'(w[7:4]) >= NUM_INPUTS);
    endfunction

    function automatic logic [10:0] rand_word_ok();
        logic [2:0] f = 3'($urandom_range(7));
        logic [3:0] b = 4'($urandom_range(NUM_INPUTS - 1));
        logic [3:0] a = 4'($urandom_range(NUM_INPUTS - 1));
        return {f, b, a};
    endfunction

    task automatic check_conf(input string tag);
        check({tag, "_func"}, {40'd0, conf_func_all}, model_func());
        check({tag, "_ins"}, conf_ins_all, model_ins());
    endtask

    // gap_mode: 0 valid every cycle, 1 alternating, 2 random.
    task automatic run_load(input int gap_mode, input int abort_at, input bit noise,
                            output bit done_seen);
        int n;
        int k;
        int t0;
        bit v;
        bit aborted;
        n = 0; k = 0; aborted = 1'b0; done_seen = 1'b0;
        start = 1'b1; abort = noise; in_valid = noise; in_data = 11'h7FF;
        t0 = ticks;
        tick();
        start = 1'b0; abort = 1'b0; in_valid = 1'b0;
        exp_err = 1'b0;
        while (n < NUM_LE && !aborted) begin
            check("load_ready", in_ready, 1);
            check("load_busy", busy, 1);
            check("load_done", done, 0);
            check("load_count", load_count, n);
            check("load_err", err, exp_err);
            check_conf("load_conf");
            if (k > 200) begin
                checks++;
                failures++;
                $display("FAIL load_timeout: got %0d words expected %0d", n, NUM_LE);
                break;
            end
            v = (gap_mode == 0) ? 1'b1 : (gap_mode == 1) ? (k % 2 == 0) : 1'($urandom % 2);
            in_valid = v;
            in_data  = v ? ld_words[n] : 11'($urandom);
            abort    = v && (n == abort_at);
            start    = noise ? 1'($urandom % 2) : 1'b0;
            tick();
            if (abort) begin
                aborted = 1'b1;
            end else if (v) begin
                if (RC && word_bad(ld_words[n])) exp_err = 1'b1;
                n++;
            end
            k++;
        end
        in_valid = 1'b0; start = 1'b0; abort = 1'b0;
        if (aborted) begin
            check("abort_ready", in_ready, 0);
            check("abort_busy", busy, 0);
            check("abort_count", load_count, n);
            check("abort_err", err, exp_err);
            check_conf("abort_conf");
            done_seen = done;
            tick();
            done_seen = done_seen | done;
            check("abort_no_done", done, 0);
        end else if (exp_err) begin
            check("rc_busy", busy, 0);
            check("rc_ready", in_ready, 0);
            check("rc_err", err, 1);
            check("rc_count", load_count, NUM_LE);
            check_conf("rc_conf");
            done_seen = done;
            tick();
            done_seen = done_seen | done;
            check("rc_no_done", done, 0);
            check("rc_err_hold", err, 1);
        end else begin
            check("commit_busy", busy, 1);
            check("commit_ready", in_ready, 0);
            check("commit_done", done, 0);
            check("commit_count", load_count, NUM_LE);
            check_conf("commit_conf_old");
            abort = noise;
            tick();
            abort = 1'b0;
            for (int i = 0; i < NUM_LE; i++) exp_act[i] = ld_words[i];
            done_seen = done;
            check("done_pulse", done, 1);
            check("done_busy", busy, 0);
            check_conf("done_conf");
            if (gap_mode == 0 && !noise) check("start_to_done", ticks - t0, NUM_LE + 2);
            tick();
            check("done_one_cycle", done, 0);
            check_conf("after_conf");
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit d;
        bit exp_d;
        int ab;
        rst = 1'b1; start = 1'b0; abort = 1'b0; in_valid = 1'b0; in_data = '0;
        for (int i = 0; i < NUM_LE; i++) exp_act[i] = '0;
        tick();
        tick();
        check("rst_ready", in_ready, 0);
        check("rst_done", done, 0);
        check("rst_busy", busy, 0);
        check("rst_err", err, 0);
        check("rst_count", load_count, 0);
        check_conf("rst_conf");
        rst = 1'b0;
        start = 1'b0;
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("idle_ready", in_ready, 0);
        check("idle_busy", busy, 0);
        check_conf("idle_conf");

        for (int i = 0; i < NUM_LE; i++) ld_words[i] = 11'((i * 32'h111) & 32'h7FF);
        run_load(0, -1, 0, d);
        check("full_done", d, 1);

        for (int i = 0; i < NUM_LE; i++) ld_words[i] = rand_word_ok();
        run_load(1, -1, 0, d);
        check("gap_done", d, 1);

        for (int i = 0; i < NUM_LE; i++) ld_words[i] = rand_word_ok();
        run_load(0, 5, 0, d);
        check("abort5_done", d, 0);
        run_load(2, -1, 0, d);
        check("fresh_done", d, 1);

        vecs[0] = '{gap_mode: 0, abort_at: -1, noise: 1'b1, exp_done: 1'b1};
        vecs[1] = '{gap_mode: 1, abort_at: -1, noise: 1'b1, exp_done: 1'b1};
        vecs[2] = '{gap_mode: 2, abort_at: -1, noise: 1'b0, exp_done: 1'b1};
        vecs[3] = '{gap_mode: 2, abort_at: 0,  noise: 1'b0, exp_done: 1'b0};
        vecs[4] = '{gap_mode: 1, abort_at: 7,  noise: 1'b1, exp_done: 1'b0};
        vecs[5] = '{gap_mode: 0, abort_at: 3,  noise: 1'b1, exp_done: 1'b0};
        for (int v = 0; v < 6; v++) begin
            for (int i = 0; i < NUM_LE; i++) ld_words[i] = rand_word_ok();
            run_load(vecs[v].gap_mode, vecs[v].abort_at, vecs[v].noise, d);
            check("vec_done", d, vecs[v].exp_done);
        end

        for (int r = 0; r < 16; r++) begin
            exp_d = 1'b1;
            for (int i = 0; i < NUM_LE; i++) begin
                ld_words[i] = 11'($urandom);
                if (RC && word_bad(ld_words[i])) exp_d = 1'b0;
            end
            ab = ($urandom % 4 == 0) ? int'($urandom % NUM_LE) : -1;
            if (ab >= 0) exp_d = 1'b0;
            run_load(int'($urandom % 3), ab, 1'($urandom % 2), d);
            check("rand_done", d, exp_d);
        end

`ifdef GENOME_LOADER_RANGE_CHECK_EN
        for (int i = 0; i < NUM_LE; i++) ld_words[i] = 11'((i * 32'h111) & 32'h7FF);
        ld_words[3] = 11'h0B1;
        run_load(0, -1, 0, d);
        check("rc_word3_done", d, 0);
        for (int i = 0; i < NUM_LE; i++) ld_words[i] = rand_word_ok();
        run_load(0, -1, 0, d);
        check("rc_recover_done", d, 1);
`endif

        for (int i = 0; i < NUM_LE; i++) ld_words[i] = rand_word_ok();
        start = 1'b1;
        tick();
        start = 1'b0;
        in_valid = 1'b1;
        for (int n = 0; n < NUM_LE; n++) begin
            in_data = ld_words[n];
            tick();
        end
        in_valid = 1'b0;
        check("pre_rst_busy", busy, 1);
        check("pre_rst_ready", in_ready, 0);
        rst = 1'b1;
        tick();
        for (int i = 0; i < NUM_LE; i++) exp_act[i] = '0;
        check("rstc_done", done, 0);
        check("rstc_busy", busy, 0);
        check("rstc_ready", in_ready, 0);
        check("rstc_count", load_count, 0);
        check("rstc_err", err, 0);
        check_conf("rstc_conf");
        rst = 1'b0;
        tick();
        check("rstc_no_done", done, 0);
        check_conf("rstc_conf_hold");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
